// File: rtl/key_cfg_ctrl.sv
// Key-driven configuration sequencer: IDLE/EDIT/COMMIT over a shadow mode/parameter pair,
// committed downstream via valid/ready. Define KEY_CFG_PARAM_WRAP_EN for wrapping parameter edits.
module key_cfg_ctrl #(
    parameter int unsigned MODE_NUM    = 4,
    parameter int unsigned PARAM_W     = 8,
    parameter int unsigned PARAM_MAX   = 255,
    parameter int unsigned PARAM_INIT  = 0,
    parameter int unsigned STEP        = 1,
    parameter int unsigned TIMEOUT_CYC = 150_000_000
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst_n,
    input  logic                        iKey1,
    input  logic                        iKey2,
    input  logic                        iKey3,
    output logic [$clog2(MODE_NUM)-1:0] oMode,
    output logic [PARAM_W-1:0]          oParam,
    output logic                        oCfgValid,
    input  logic                        iCfgReady,
    output logic                        oEditing,
    output logic [$clog2(MODE_NUM)-1:0] oEditMode,
    output logic [PARAM_W-1:0]          oEditParam
);

    localparam int unsigned MODE_W = $clog2(MODE_NUM);
    localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYC);

    localparam logic [MODE_W-1:0]  MODE_LAST = MODE_W'(MODE_NUM - 1);
    localparam logic [PARAM_W:0]   STEP_X    = (PARAM_W + 1)'(STEP);
    localparam logic [PARAM_W:0]   MAX_X     = (PARAM_W + 1)'(PARAM_MAX);
    localparam logic [PARAM_W-1:0] STEP_N    = PARAM_W'(STEP);
    localparam logic [PARAM_W-1:0] MAX_N     = PARAM_W'(PARAM_MAX);
    localparam logic [PARAM_W-1:0] PARAM_RST = PARAM_W'(PARAM_INIT);
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        EDIT,
        COMMIT
    } stateT;

    stateT             state;
    stateT             stateNext;
    logic [CNT_W-1:0]  idleCnt;
    logic              keyAny;
    logic              timeoutHit;
    logic [PARAM_W:0]  paramUp;
    logic [PARAM_W-1:0] paramInc;
    logic [PARAM_W-1:0] paramDec;

    assign keyAny     = iKey1 | iKey2 | iKey3;
    assign timeoutHit = (state == EDIT) && !keyAny && (idleCnt == CNT_LAST);

    // Extra headroom bit lets the upper bound be detected without wrapping.
    always_comb begin
        paramUp  = {1'b0, oEditParam} + STEP_X;
`ifdef KEY_CFG_PARAM_WRAP_EN
        paramInc = (paramUp > MAX_X) ? '0 : paramUp[PARAM_W-1:0];
        paramDec = (oEditParam < STEP_N) ? MAX_N : oEditParam - STEP_N;
`else
        paramInc = (paramUp > MAX_X) ? MAX_N : paramUp[PARAM_W-1:0];
        paramDec = (oEditParam < STEP_N) ? '0 : oEditParam - STEP_N;
`endif
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) state <= IDLE;
        else            state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (iKey1)      stateNext = EDIT;
            EDIT:    if (timeoutHit) stateNext = COMMIT;
            COMMIT:  if (iCfgReady)  stateNext = IDLE;
            default:                 stateNext = IDLE;
        endcase
    end

    always_comb begin
        oEditing  = (state == EDIT);
        oCfgValid = (state == COMMIT);
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            oMode      <= '0;
            oParam     <= PARAM_RST;
            oEditMode  <= '0;
            oEditParam <= PARAM_RST;
            idleCnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (iKey1) begin
                        oEditMode  <= oMode;
                        oEditParam <= oParam;
                        idleCnt    <= '0;
                    end
                end
                EDIT: begin
                    if (keyAny) idleCnt <= '0;
                    else        idleCnt <= idleCnt + 1'b1;
                    // Mode key wins; opposing up/down pulses cancel each other.
                    if (iKey1)
                        oEditMode <= (oEditMode == MODE_LAST) ? '0 : oEditMode + 1'b1;
                    else if (iKey2 && !iKey3)
                        oEditParam <= paramInc;
                    else if (iKey3 && !iKey2)
                        oEditParam <= paramDec;
                    if (timeoutHit) begin
                        oMode   <= oEditMode;
                        oParam  <= oEditParam;
                        idleCnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_key_cfg_ctrl.sv
// Self-checking bench for key_cfg_ctrl: directed scenarios plus randomized keys/ready/reset
// against a cycle-level behavioural model of the edit/commit rules.
module tb_key_cfg_ctrl;

    localparam int MN = 3, PW = 4, PMAX = 10, PINIT = 5, STP = 3, TO = 16;
`ifdef KEY_CFG_PARAM_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rstN, k1, k2, k3, rdy;
    logic [1:0] oMode, oEditMode;
    logic [3:0] oParam, oEditParam;
    logic       oCfgValid, oEditing;
    logic [13:0] dutVec;

    int checks = 0;
    int failures = 0;

    // Behavioural model state
    int mMode, mParam, mEdMode, mEdParam, mQuiet;
    bit mEditing, mValid;

    always #5 clk = ~clk;

    key_cfg_ctrl #(
        .MODE_NUM(MN), .PARAM_W(PW), .PARAM_MAX(PMAX),
        .PARAM_INIT(PINIT), .STEP(STP), .TIMEOUT_CYC(TO)
    ) dut (
        .sys_clk(clk), .sys_rst_n(rstN),
        .iKey1(k1), .iKey2(k2), .iKey3(k3),
        .oMode(oMode), .oParam(oParam), .oCfgValid(oCfgValid), .iCfgReady(rdy),
        .oEditing(oEditing), .oEditMode(oEditMode), .oEditParam(oEditParam)
    );

    assign dutVec = {oMode, oParam, oCfgValid, oEditing, oEditMode, oEditParam};

    function automatic logic [13:0] expVec();
        return {2'(mMode), 4'(mParam), mValid, mEditing, 2'(mEdMode), 4'(mEdParam)};
    endfunction

    // Drive one cycle, advance the model by the same edge, then settle for sampling.
    task automatic tick(input bit r, input bit a, input bit b, input bit c, input bit d);
        int p;
        rstN = r; k1 = a; k2 = b; k3 = c; rdy = d;
        @(posedge clk);
        if (!r) begin
            mMode = 0; mParam = PINIT; mEdMode = 0; mEdParam = PINIT;
            mQuiet = 0; mEditing = 0; mValid = 0;
        end else if (mValid) begin
            if (d) mValid = 0;
        end else if (mEditing) begin
            if (a) mEdMode = (mEdMode + 1) % MN;
            else if (b && !c) begin
                p = mEdParam + STP;
                if (p > PMAX) p = WRAP ? 0 : PMAX;
                mEdParam = p;
            end else if (c && !b) begin
                p = mEdParam - STP;
                if (p < 0) p = WRAP ? PMAX : 0;
                mEdParam = p;
            end
            if (a || b || c) mQuiet = 0;
            else             mQuiet++;
            if (mQuiet == TO) begin
                mEditing = 0; mValid = 1; mMode = mEdMode; mParam = mEdParam;
            end
        end else if (a) begin
            mEditing = 1; mEdMode = mMode; mEdParam = mParam; mQuiet = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        tick(0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0);
        checks++;
        if (dutVec !== {2'd0, 4'd5, 1'b0, 1'b0, 2'd0, 4'd5}) begin
            failures++; $display("FAIL reset_values: got=%h exp=%h", dutVec, {2'd0, 4'd5, 4'd0, 4'd5});
        end
        for (int i = 0; i < 12; i++) begin
            tick(1, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            checks++;
            if (oMode !== 2'd0 || oParam !== 4'd5 || oCfgValid !== 1'b0 || oEditing !== 1'b0) begin
                failures++; $display("FAIL idle_keys_ignored: got=%h exp=%h", dutVec, expVec());
            end
        end
    endtask

    task automatic test_mode_cycle();
        int n;
        logic [1:0] modeSeq [3] = '{2'd1, 2'd2, 2'd0};
        tick(0, 0, 0, 0, 0);
        tick(1, 1, 0, 0, 0);
        checks++;
        if (oEditing !== 1'b1 || oEditMode !== 2'd0) begin
            failures++; $display("FAIL edit_entry: got=%h exp=%h", dutVec, expVec());
        end
        for (int i = 0; i < 3; i++) begin
            tick(1, 1, 0, 0, 1);
            checks++;
            if (oEditMode !== modeSeq[i]) begin
                failures++; $display("FAIL mode_step%0d: got=%0d exp=%0d", i, oEditMode, modeSeq[i]);
            end
        end
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1, 0, 0, 0, 1);
            n++;
            checks++;
            if (dutVec !== expVec()) begin
                failures++; $display("FAIL mode_wait: got=%h exp=%h", dutVec, expVec());
            end
            if (oCfgValid === 1'b1) break;
        end
        checks++;
        if (n != TO || oMode !== 2'd0) begin
            failures++; $display("FAIL mode_commit_latency: got=%0d/mode%0d exp=%0d/mode0", n, oMode, TO);
        end
        tick(1, 0, 0, 0, 1);
        checks++;
        if (oCfgValid !== 1'b0 || oEditing !== 1'b0) begin
            failures++; $display("FAIL valid_one_cycle: got=%b exp=0", oCfgValid);
        end
    endtask

    task automatic test_param_up();
        logic [3:0] seq [3];
        seq = WRAP ? '{4'd8, 4'd0, 4'd3} : '{4'd8, 4'd10, 4'd10};
        tick(0, 0, 0, 0, 0);
        tick(1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick(1, 0, 1, 0, 0);
            checks++;
            if (oEditParam !== seq[i]) begin
                failures++; $display("FAIL param_up%0d: got=%0d exp=%0d", i, oEditParam, seq[i]);
            end
        end
        for (int i = 0; i < 40 && oCfgValid !== 1'b1; i++) tick(1, 0, 0, 0, 0);
        checks++;
        if (oCfgValid !== 1'b1 || oParam !== seq[2]) begin
            failures++; $display("FAIL param_up_commit: got=v%b/%0d exp=v1/%0d", oCfgValid, oParam, seq[2]);
        end
        tick(1, 0, 0, 0, 1);
    endtask

    task automatic test_param_down();
        int n;
        logic [3:0] seq [2];
        seq = WRAP ? '{4'd2, 4'd10} : '{4'd2, 4'd0};
        tick(0, 0, 0, 0, 0);
        tick(1, 1, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            tick(1, 0, 0, 1, 0);
            checks++;
            if (oEditParam !== seq[i]) begin
                failures++; $display("FAIL param_down%0d: got=%0d exp=%0d", i, oEditParam, seq[i]);
            end
        end
        for (int i = 0; i < 10; i++) tick(1, 0, 0, 0, 0);
        tick(1, 0, 1, 1, 1);
        checks++;
        if (oEditParam !== seq[1] || oEditing !== 1'b1) begin
            failures++; $display("FAIL up_down_cancel: got=%0d exp=%0d", oEditParam, seq[1]);
        end
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1, 0, 0, 0, 1);
            n++;
            if (oCfgValid === 1'b1) break;
        end
        checks++;
        if (n != TO || oParam !== seq[1]) begin
            failures++; $display("FAIL timeout_restart: got=%0d/%0d exp=%0d/%0d", n, oParam, TO, seq[1]);
        end
        tick(1, 0, 0, 0, 1);
    endtask

    task automatic test_commit_hold();
        tick(0, 0, 0, 0, 0);
        tick(1, 1, 0, 0, 0);
        tick(1, 0, 1, 0, 0);
        for (int i = 0; i < 40 && oCfgValid !== 1'b1; i++) tick(1, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            tick(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
            checks++;
            if (oCfgValid !== 1'b1 || oEditing !== 1'b0 || oMode !== 2'd0 || oParam !== 4'd8
                || dutVec !== expVec()) begin
                failures++; $display("FAIL commit_hold%0d: got=%h exp=%h", i, dutVec, expVec());
            end
        end
        tick(1, 1, 0, 0, 1);
        checks++;
        if (oCfgValid !== 1'b0 || oEditing !== 1'b0 || oParam !== 4'd8) begin
            failures++; $display("FAIL handshake_to_idle: got=%h exp=%h", dutVec, expVec());
        end
    endtask

    task automatic test_reset_mid();
        tick(0, 0, 0, 0, 0);
        tick(1, 1, 0, 0, 0);
        tick(1, 1, 1, 0, 0);
        tick(1, 0, 1, 0, 0);
        tick(0, 0, 0, 0, 0);
        checks++;
        if (dutVec !== {2'd0, 4'd5, 1'b0, 1'b0, 2'd0, 4'd5}) begin
            failures++; $display("FAIL reset_mid_edit: got=%h exp=%h", dutVec, expVec());
        end
        tick(1, 1, 0, 0, 0);
        tick(1, 0, 0, 1, 0);
        for (int i = 0; i < 40 && oCfgValid !== 1'b1; i++) tick(1, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 1);
        checks++;
        if (dutVec !== {2'd0, 4'd5, 1'b0, 1'b0, 2'd0, 4'd5}) begin
            failures++; $display("FAIL reset_mid_commit: got=%h exp=%h", dutVec, expVec());
        end
        tick(1, 0, 0, 0, 1);
        checks++;
        if (oCfgValid !== 1'b0 || oMode !== 2'd0 || oParam !== 4'd5) begin
            failures++; $display("FAIL payload_dropped: got=%h exp=%h", dutVec, expVec());
        end
    endtask

    task automatic test_random();
        tick(0, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            tick(($urandom_range(0, 299) != 0),
                 ($urandom_range(0, 29) == 0), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)));
            checks++;
            if (dutVec !== expVec()) begin
                failures++; $display("FAIL random_cyc%0d: got=%h exp=%h", i, dutVec, expVec());
            end
        end
    endtask

    initial begin
        rstN = 1'b0; k1 = 1'b0; k2 = 1'b0; k3 = 1'b0; rdy = 1'b0;
        test_reset();
        test_mode_cycle();
        test_param_up();
        test_param_down();
        test_commit_hold();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
